// File: rtl/ks_add_sched.sv
// Round-robin scheduler sharing one external 8-bit Kogge-Stone adder between two
// requesters; a 32-bit add takes 4 slice cycles. Optional KS_OVF_EN adds a signed overflow flag.
`timescale 1ns/1ps
module ks_add_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        cin0,
  input  logic        cin1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic [7:0]  slice_a,
  output logic [7:0]  slice_b,
  output logic        slice_cin,
  input  logic [7:0]  slice_sum,
  input  logic        slice_cout,
  output logic        done,
  output logic        done_id,
  output logic [31:0] sum,
  output logic        cout
`ifdef KS_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic        lp_q, lp_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic        id_q, id_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        done_id_q, done_id_d;
  logic        sel1;
`ifdef KS_OVF_EN
  logic        ovf_q, ovf_d;
`endif

  // On a tie the requester that was not served last wins.
  assign sel1 = req1 && (!req0 || !lp_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    lp_d      = lp_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    id_d      = id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    done_id_d = done_id_q;
`ifdef KS_OVF_EN
    ovf_d     = ovf_q;
`endif
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if ((req0 || req1) && !rst) begin
          gnt0    = !sel1;
          gnt1    = sel1;
          a_d     = sel1 ? a1 : a0;
          b_d     = sel1 ? b1 : b0;
          cin_d   = sel1 ? cin1 : cin0;
          id_d    = sel1;
          lp_d    = sel1;
          idx_d   = 2'd0;
          carry_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        slice_a   = a_q[{idx_q, 3'b000} +: 8];
        slice_b   = b_q[{idx_q, 3'b000} +: 8];
        slice_cin = (idx_q == 2'd0) ? cin_q : carry_q;
        sum_d[{idx_q, 3'b000} +: 8] = slice_sum;
        carry_d   = slice_cout;
        idx_d     = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // Flags and id are committed only here so they stay stable from DONE to DONE.
          cout_d    = slice_cout;
          done_id_d = id_q;
`ifdef KS_OVF_EN
          ovf_d     = (a_q[31] == b_q[31]) && (slice_sum[7] != a_q[31]);
`endif
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      lp_q      <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      id_q      <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_id_q <= 1'b0;
`ifdef KS_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      lp_q      <= lp_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      id_q      <= id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      done_id_q <= done_id_d;
`ifdef KS_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
`ifdef KS_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule
